// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer that lends one registered, enable-gated
// adder to NREQ requesters, one transaction at a time.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant; pick next requester after ptr, latch its operands
// S_ISSUE | add_en high for one cycle, load latency counter
// S_WAIT  | count down adder latency; capture sum/ovf at terminal count
// S_DONE  | done pulse for one cycle, then drop grant and advance ptr
module adder_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int ADD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] op_a,
   input  logic [NREQ*W-1:0] op_b,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      res_sum,
   output logic              res_ovf,
   output logic              busy,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   output logic              add_en,
   input  logic [W-1:0]      add_sum,
   input  logic              add_ovf
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(ADD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            sel_vld;
   logic [IW-1:0]   sel_idx;
   int              cand;

   // round-robin pick: scan farthest-from-ptr first so the nearest requester
   // after ptr wins; ptr itself has the lowest priority
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = (int'(ptr) + k) % NREQ;
         if (req[cand]) begin
            sel_vld = 1'b1;
            sel_idx = IW'(cand);
         end
      end
   end

   // adder enable and busy are pure state decodes, so no path from req
   assign add_en = (state == S_ISSUE);
   assign busy   = (state != S_IDLE);

   // sequencer: grant, operand latch, latency countdown, result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         gnt     <= '0;
         done    <= '0;
         res_sum <= '0;
         res_ovf <= 1'b0;
         add_a   <= '0;
         add_b   <= '0;
         cnt     <= '0;
         idx     <= '0;
         ptr     <= IW'(NREQ - 1);
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_vld) begin
                  gnt   <= ONE_HOT0 << sel_idx;
                  add_a <= op_a[sel_idx*W +: W];
                  add_b <= op_b[sel_idx*W +: W];
                  idx   <= sel_idx;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt   <= CNT_LOAD;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  res_sum <= add_sum;
                  res_ovf <= add_ovf;
                  done    <= ONE_HOT0 << idx;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DONE: begin
               gnt   <= '0;
               done  <= '0;
               ptr   <= idx;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: one instance with a single-stage adder,
// one with a three-stage adder, each fed by a small behavioural adder.
module tb_adder_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // instance a: ADD_LAT = 1
   logic [3:0]  a_req = '0, a_gnt, a_done, a_res_sum, a_add_a, a_add_b;
   logic [15:0] a_opa = '0, a_opb = '0;
   logic        a_res_ovf, a_busy, a_add_en;
   logic [3:0]  a_add_sum = '0;
   logic        a_add_ovf = 1'b0;

   // instance b: ADD_LAT = 3
   logic [3:0]  b_req = '0, b_gnt, b_done, b_res_sum, b_add_a, b_add_b;
   logic [15:0] b_opa = '0, b_opb = '0;
   logic        b_res_ovf, b_busy, b_add_en;
   logic [3:0]  b_add_sum = '0;
   logic        b_add_ovf = 1'b0;

   adder_arbiter #(.NREQ(4), .W(4), .ADD_LAT(1)) u_a (
      .clk(clk), .rst(rst), .req(a_req), .op_a(a_opa), .op_b(a_opb),
      .gnt(a_gnt), .done(a_done), .res_sum(a_res_sum), .res_ovf(a_res_ovf),
      .busy(a_busy), .add_a(a_add_a), .add_b(a_add_b), .add_en(a_add_en),
      .add_sum(a_add_sum), .add_ovf(a_add_ovf)
   );

   adder_arbiter #(.NREQ(4), .W(4), .ADD_LAT(3)) u_b (
      .clk(clk), .rst(rst), .req(b_req), .op_a(b_opa), .op_b(b_opb),
      .gnt(b_gnt), .done(b_done), .res_sum(b_res_sum), .res_ovf(b_res_ovf),
      .busy(b_busy), .add_a(b_add_a), .add_b(b_add_b), .add_en(b_add_en),
      .add_sum(b_add_sum), .add_ovf(b_add_ovf)
   );

   // single-stage adder, output held while add_en is low
   always @(posedge clk) begin
      if (a_add_en) {a_add_ovf, a_add_sum} <= {1'b0, a_add_a} + {1'b0, a_add_b};
   end

   // three-stage adder; output register only updates when a result arrives
   logic [4:0] b_s1 = '0, b_s2 = '0;
   logic       b_v1 = 1'b0, b_v2 = 1'b0;
   always @(posedge clk) begin
      b_v1 <= b_add_en;
      if (b_add_en) b_s1 <= {1'b0, b_add_a} + {1'b0, b_add_b};
      b_v2 <= b_v1;
      b_s2 <= b_s1;
      if (b_v2) {b_add_ovf, b_add_sum} <= b_s2;
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_gnt", int'(a_gnt), 0);
      check_val("rst_done", int'(a_done), 0);
      check_val("rst_busy", int'(a_busy), 0);
      check_val("rst_add_en", int'(a_add_en), 0);
      check_val("rst_add_a", int'(a_add_a), 0);
      check_val("rst_res_sum", int'(a_res_sum), 0);
      check_val("rst_b_gnt", int'(b_gnt), 0);
      rst = 1'b0;

      // single request: 9 + 10 = 19 -> sum 3, carry 1
      a_opa[0 +: 4] = 4'd9;
      a_opb[0 +: 4] = 4'd10;
      a_req = 4'b0001;
      tick();
      check_val("t1_gnt", int'(a_gnt), 1);
      check_val("t1_add_en", int'(a_add_en), 1);
      check_val("t1_add_a", int'(a_add_a), 9);
      check_val("t1_add_b", int'(a_add_b), 10);
      check_val("t1_busy", int'(a_busy), 1);
      tick();
      check_val("t1_add_en_off", int'(a_add_en), 0);
      check_val("t1_done_early", int'(a_done), 0);
      tick();
      check_val("t1_done", int'(a_done), 1);
      check_val("t1_sum", int'(a_res_sum), 3);
      check_val("t1_ovf", int'(a_res_ovf), 1);
      a_req = 4'b0000;
      tick();
      check_val("t1_done_off", int'(a_done), 0);
      check_val("t1_gnt_off", int'(a_gnt), 0);
      check_val("t1_busy_off", int'(a_busy), 0);
      check_val("t1_sum_held", int'(a_res_sum), 3);

      // fairness: requester 0 just served, so 2 goes before 0
      a_opa[8 +: 4] = 4'd1;
      a_opb[8 +: 4] = 4'd1;
      a_req = 4'b0101;
      tick();
      check_val("t3_gnt_first", int'(a_gnt), 4);
      tick();
      tick();
      check_val("t3_done_first", int'(a_done), 4);
      check_val("t3_sum_first", int'(a_res_sum), 2);
      tick();
      tick();
      check_val("t3_gnt_second", int'(a_gnt), 1);
      tick();
      tick();
      check_val("t3_done_second", int'(a_done), 1);
      check_val("t3_sum_second", int'(a_res_sum), 3);
      a_req = 4'b0000;
      tick();

      // all requesters held: order 0,1,2,3,0 with a 4-cycle period
      pulse_rst();
      for (int i = 0; i < 4; i++) begin
         a_opa[i*4 +: 4] = 4'(i + 1);
         a_opb[i*4 +: 4] = 4'd2;
      end
      a_req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         tick();
         check_val($sformatf("t2_gnt%0d", t), int'(a_gnt), 1 << (t % 4));
         tick();
         check_val($sformatf("t2_wait%0d", t), int'(a_done), 0);
         tick();
         check_val($sformatf("t2_done%0d", t), int'(a_done), 1 << (t % 4));
         check_val($sformatf("t2_sum%0d", t), int'(a_res_sum), (t % 4) + 3);
         check_val($sformatf("t2_ovf%0d", t), int'(a_res_ovf), 0);
         if (t == 4) a_req = 4'b0000;
         tick();
         check_val($sformatf("t2_idle%0d", t), int'(a_gnt), 0);
      end

      // reset during WAIT: asynchronous clear, no done pulse
      a_req = 4'b0100;
      tick();
      check_val("t4_gnt", int'(a_gnt), 4);
      a_req = 4'b0000;
      tick();
      #2 rst = 1'b1;
      #1;
      check_val("t4_async_gnt", int'(a_gnt), 0);
      check_val("t4_async_busy", int'(a_busy), 0);
      check_val("t4_async_add_a", int'(a_add_a), 0);
      check_val("t4_async_add_b", int'(a_add_b), 0);
      check_val("t4_async_done", int'(a_done), 0);
      tick();
      check_val("t4_no_done", int'(a_done), 0);
      check_val("t4_res_sum", int'(a_res_sum), 0);
      #2 rst = 1'b0;
      a_req = 4'b0010;
      tick();
      check_val("t4_gnt_after", int'(a_gnt), 2);
      tick();
      tick();
      check_val("t4_done_after", int'(a_done), 2);
      check_val("t4_sum_after", int'(a_res_sum), 4);
      a_req = 4'b0011;
      tick();
      tick();
      check_val("t4_gnt_next", int'(a_gnt), 1);
      tick();
      tick();
      check_val("t4_done_next", int'(a_done), 1);
      a_req = 4'b0000;
      tick();

      // requester drops req in WAIT and changes its operand
      a_opa[8 +: 4] = 4'd5;
      a_opb[8 +: 4] = 4'd6;
      a_req = 4'b0100;
      tick();
      check_val("t6_gnt", int'(a_gnt), 4);
      check_val("t6_add_a", int'(a_add_a), 5);
      tick();
      a_req = 4'b0000;
      a_opa[8 +: 4] = 4'd15;
      tick();
      check_val("t6_done", int'(a_done), 4);
      check_val("t6_sum", int'(a_res_sum), 11);
      check_val("t6_ovf", int'(a_res_ovf), 0);
      check_val("t6_add_a_held", int'(a_add_a), 5);
      tick();
      tick();
      check_val("t6_idle_gnt", int'(a_gnt), 0);
      check_val("t6_idle_busy", int'(a_busy), 0);

      // three-cycle adder: 7 + 8 = 15, done ADD_LAT+1 edges after grant
      b_opa[4 +: 4] = 4'd7;
      b_opb[4 +: 4] = 4'd8;
      b_req = 4'b0010;
      tick();
      check_val("t5_gnt", int'(b_gnt), 2);
      check_val("t5_add_en", int'(b_add_en), 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_val($sformatf("t5_add_en_off%0d", c), int'(b_add_en), 0);
         check_val($sformatf("t5_no_done%0d", c), int'(b_done), 0);
      end
      tick();
      check_val("t5_done", int'(b_done), 2);
      check_val("t5_sum", int'(b_res_sum), 15);
      check_val("t5_ovf", int'(b_res_ovf), 0);
      b_req = 4'b0000;
      tick();
      check_val("t5_done_off", int'(b_done), 0);
      check_val("t5_gnt_off", int'(b_gnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
